// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared pipeline encodings (FSM states, MEM control bits, NOP)
// Rev 1.0
// ============================================================================
package pipe_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        RUN     = ST_RUN,
        HOLD    = ST_HOLD,
        FLUSH   = ST_FLUSH,
        ILLEGAL = 2'd3
    } state_t;

    localparam int MEM_BRANCH_BIT = 2;
    localparam int MEM_READ_BIT   = 1;
    localparam int MEM_WRITE_BIT  = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating up-counter with synchronous clear (clear wins)
// Rev 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : decode-stage load-use / memory-hold / branch-flush sequencer
// Rev 1.0
// ============================================================================
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             clr_stats,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
);

    localparam logic [3:0] c_reload = 4'(FLUSH_CYCLES - 1);
    localparam bit         c_multi  = (FLUSH_CYCLES > 1);

    state_t     r_state, w_state_nxt;
    logic       r_pend, w_pend_nxt;
    logic [3:0] r_fcnt, w_fcnt_nxt;
    logic       w_lu;
    logic       w_br_req;
    logic       w_flush_inc;

    assign w_lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    // A branch seen while frozen is replayed through pend on release
    assign w_br_req = r_pend | branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_pend  <= 1'b0;
            r_fcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend;
        w_fcnt_nxt   = r_fcnt;
        w_flush_inc  = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        hold         = 1'b0;

        case (r_state)
            RUN, HOLD: begin
                if (mem_busy) begin
                    hold        = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    w_pend_nxt  = w_br_req;
                    w_state_nxt = HOLD;
                end else if (w_br_req) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_flush_inc  = 1'b1;
                    w_pend_nxt   = 1'b0;
                    w_fcnt_nxt   = c_reload;
                    w_state_nxt  = c_multi ? FLUSH : RUN;
                end else begin
                    if (w_lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                // IF/ID holds a NOP here, so load-use is not evaluated
                if (mem_busy) begin
                    hold        = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    w_pend_nxt  = w_br_req;
                end else begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (w_br_req) begin
                        w_flush_inc = 1'b1;
                        w_pend_nxt  = 1'b0;
                        w_fcnt_nxt  = c_reload;
                        w_state_nxt = c_multi ? FLUSH : RUN;
                    end else begin
                        w_fcnt_nxt  = r_fcnt - 4'd1;
                        w_state_nxt = (r_fcnt <= 4'd1) ? RUN : FLUSH;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase

        if (!rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b0;
            hold         = 1'b0;
        end
    end

    assign state_o = r_state;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (!pc_write),
        .clr   (clr_stats),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (w_flush_inc),
        .clr   (clr_stats),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire
